// File: rtl/hex_display_scanner_if.sv
// Bus between the hex scan driver and its user: value/decimal-point load port plus the
// per-digit scan outputs that feed the 7-segment decoder and the anode drivers.
interface hex_display_scanner_if #(
  parameter int NUMDIGITS = 4
);
  logic [4*NUMDIGITS-1:0] valuein;
  logic [NUMDIGITS-1:0]   decpointsin;
  logic                   load;
  logic                   blankzeros;
  logic [3:0]             binaryout;
  logic                   decout;
  logic [NUMDIGITS-1:0]   anode;
  logic                   blank;
  logic                   framedone;

  modport master (
    output valuein, decpointsin, load, blankzeros,
    input  binaryout, decout, anode, blank, framedone
  );

  modport slave (
    input  valuein, decpointsin, load, blankzeros,
    output binaryout, decout, anode, blank, framedone
  );
endinterface

// File: rtl/hex_display_scanner.sv
// Time-multiplexed scan driver for a common-anode hex display with a double-buffered value
// register; new values only take effect at a frame boundary.
module hex_display_scanner #(
  parameter int NUMDIGITS  = 4,
  parameter int REFRESHDIV = 50000,
  parameter int CNTW       = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  hex_display_scanner_if.slave  bus
);
  localparam int DW = (NUMDIGITS > 1) ? $clog2(NUMDIGITS) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(REFRESHDIV - 1);
  localparam logic [DW-1:0]   DIG_LAST = DW'(NUMDIGITS - 1);

  logic [CNTW-1:0]        cnt;
  logic [DW-1:0]          digit;
  logic [4*NUMDIGITS-1:0] pending_value;
  logic [NUMDIGITS-1:0]   pending_dp;
  logic                   pendingvalid;
  logic [4*NUMDIGITS-1:0] active_value;
  logic [NUMDIGITS-1:0]   active_dp;
  logic                   slot_end;
  logic                   boundary;
  logic                   zero_run;
  logic [NUMDIGITS-1:0]   blanked;

  assign slot_end = (cnt == CNT_LAST);
  assign boundary = slot_end && (digit == DIG_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt           <= '0;
      digit         <= '0;
      pending_value <= '0;
      pending_dp    <= '0;
      pendingvalid  <= 1'b0;
      active_value  <= '0;
      active_dp     <= '0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end)
        digit <= (digit == DIG_LAST) ? '0 : digit + 1'b1;
      if (boundary && pendingvalid) begin
        active_value <= pending_value;
        active_dp    <= pending_dp;
      end
      // A load coinciding with the boundary commits the older pending value and stays
      // queued itself for the following frame.
      if (bus.load) begin
        pending_value <= bus.valuein;
        pending_dp    <= bus.decpointsin;
        pendingvalid  <= 1'b1;
      end else if (boundary) begin
        pendingvalid  <= 1'b0;
      end
    end
  end

  // Scan from the most significant digit down, tracking whether every nibble so far is zero.
  always_comb begin
    blanked  = '0;
    zero_run = 1'b1;
    for (int unsigned j = 0; j < NUMDIGITS; j++) begin
      zero_run = zero_run && (active_value[4*(NUMDIGITS-1-j) +: 4] == 4'h0);
      if (j != NUMDIGITS - 1)
        blanked[NUMDIGITS-1-j] = bus.blankzeros && zero_run && !active_dp[NUMDIGITS-1-j];
    end
  end

  always_comb begin
    bus.binaryout = active_value[{digit, 2'b00} +: 4];
    bus.decout    = active_dp[digit];
    bus.anode     = '1;
    bus.blank     = 1'b1;
    bus.framedone = boundary;
    if (cnt != '0 && !blanked[digit]) begin
      bus.anode[digit] = 1'b0;
      bus.blank        = 1'b0;
    end
  end
endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner: a cycle-count based reference model predicts every output,
// with directed scenarios followed by randomized loads and leading-zero blanking.
module tb_hex_display_scanner;
  localparam int N     = 4;
  localparam int R     = 4;
  localparam int FRAME = N * R;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hex_display_scanner_if #(.NUMDIGITS(N)) bus ();

  hex_display_scanner #(
    .NUMDIGITS (N),
    .REFRESHDIV(R),
    .CNTW      (2)
  ) u_dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  // Reference model: cycles since reset, displayed value and the pending buffer.
  int unsigned cyc;
  logic [15:0] m_val, p_val;
  logic [3:0]  m_dp, p_dp;
  bit          p_valid;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cyc = 0; m_val = '0; m_dp = '0; p_val = '0; p_dp = '0; p_valid = 0;
    end else begin
      if (cyc % FRAME == FRAME - 1 && p_valid) begin
        m_val = p_val;
        m_dp  = p_dp;
      end
      if (bus.load) begin
        p_val = bus.valuein; p_dp = bus.decpointsin; p_valid = 1;
      end else if (cyc % FRAME == FRAME - 1) begin
        p_valid = 0;
      end
      cyc++;
    end
  end

  // Expected {binaryout, decout, anode, blank, framedone} for the current cycle.
  function automatic logic [10:0] expect_out();
    int unsigned slot, dig;
    logic [3:0]  nib, an;
    logic        dp, blk;
    slot = cyc % R;
    dig  = (cyc / R) % N;
    nib  = 4'((m_val >> (4 * dig)) & 16'h000F);
    dp   = m_dp[dig];
    blk  = bus.blankzeros && dig > 0 && (m_val >> (4 * dig)) == 16'h0 && !dp;
    an   = (slot == 0 || blk) ? 4'hF : ~(4'b0001 << dig);
    return {nib, dp, an, (slot == 0 || blk), (cyc % FRAME == FRAME - 1)};
  endfunction

  function automatic logic [10:0] actual_out();
    return {bus.binaryout, bus.decout, bus.anode, bus.blank, bus.framedone};
  endfunction

  task automatic test_reset();
    logic [10:0] a, e;
    resetn = 1'b0;
    bus.load = 1'b0; bus.blankzeros = 1'b0; bus.valuein = '0; bus.decpointsin = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.anode !== 4'hF) begin errors++; $display("FAIL reset_anode got=%h exp=f", bus.anode); end
    checks++; if (bus.blank !== 1'b1) begin errors++; $display("FAIL reset_blank got=%b exp=1", bus.blank); end
    checks++; if (bus.binaryout !== 4'h0) begin errors++; $display("FAIL reset_binaryout got=%h exp=0", bus.binaryout); end
    checks++; if (bus.framedone !== 1'b0) begin errors++; $display("FAIL reset_framedone got=%b exp=0", bus.framedone); end
    resetn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      a = actual_out(); e = expect_out();
      checks++; if (a !== e) begin errors++; $display("FAIL after_reset cyc=%0d got=%h exp=%h", cyc, a, e); end
    end
  endtask

  task automatic test_load_commit();
    logic [10:0] a, e;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      a = actual_out(); e = expect_out();
      checks++; if (a !== e) begin errors++; $display("FAIL load_commit cyc=%0d got=%h exp=%h", cyc, a, e); end
      bus.load = (k == 2);
      if (k == 2) begin bus.valuein = 16'h12AF; bus.decpointsin = 4'b0100; end
    end
    bus.load = 1'b0;
  endtask

  task automatic test_blankzeros();
    logic [10:0] a, e;
    bus.blankzeros = 1'b1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      a = actual_out(); e = expect_out();
      checks++; if (a !== e) begin errors++; $display("FAIL blankzeros cyc=%0d got=%h exp=%h", cyc, a, e); end
      bus.load = (k == 0 || k == 40);
      if (k == 0)  begin bus.valuein = 16'h0050; bus.decpointsin = 4'b0000; end
      if (k == 40) begin bus.valuein = 16'h0005; bus.decpointsin = 4'b0100; end
    end
    bus.load = 1'b0;
    bus.blankzeros = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [10:0] a, e;
    int phase = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      a = actual_out(); e = expect_out();
      checks++; if (a !== e) begin errors++; $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, a, e); end
      bus.load = 1'b0;
      if (phase == 0 && cyc % FRAME == 2) begin
        bus.load = 1'b1; bus.valuein = 16'h1111; bus.decpointsin = '0; phase = 1;
      end else if (phase == 1) begin
        bus.load = 1'b1; bus.valuein = 16'h2222; phase = 2;
      end else if (phase == 2 && cyc % FRAME == FRAME - 1) begin
        bus.load = 1'b1; bus.valuein = 16'h3333; phase = 3;
      end
    end
    bus.load = 1'b0;
    checks++; if (phase != 3) begin errors++; $display("FAIL back_to_back_phase got=%0d exp=3", phase); end
  endtask

  task automatic test_reset_mid();
    logic [10:0] a, e;
    bit found = 0;
    for (int k = 0; k < 2 * FRAME && !found; k++) begin
      @(negedge clk);
      if ((cyc / R) % N == 2 && cyc % R == 2) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL reset_mid_wait got=0 exp=1"); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (bus.anode !== 4'hF) begin errors++; $display("FAIL mid_reset_anode got=%h exp=f", bus.anode); end
    checks++; if (bus.blank !== 1'b1) begin errors++; $display("FAIL mid_reset_blank got=%b exp=1", bus.blank); end
    checks++; if (bus.binaryout !== 4'h0 || bus.decout !== 1'b0) begin
      errors++; $display("FAIL mid_reset_data got=%h/%b exp=0/0", bus.binaryout, bus.decout);
    end
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      a = actual_out(); e = expect_out();
      checks++; if (a !== e) begin errors++; $display("FAIL after_mid_reset cyc=%0d got=%h exp=%h", cyc, a, e); end
    end
  endtask

  task automatic test_random();
    logic [10:0] a, e;
    logic [15:0] masks [4] = '{16'hFFFF, 16'h00FF, 16'h000F, 16'h0000};
    int last_fd = -1;
    for (int k = 0; k < 160; k++) begin
      @(negedge clk);
      a = actual_out(); e = expect_out();
      checks++; if (a !== e) begin errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, a, e); end
      checks++; if ($countones(~bus.anode) > 1) begin errors++; $display("FAIL anode_onehot got=%b exp=at_most_one_low", bus.anode); end
      if (bus.framedone) begin
        if (last_fd >= 0) begin
          checks++; if (k - last_fd != FRAME) begin errors++; $display("FAIL framedone_period got=%0d exp=%0d", k - last_fd, FRAME); end
        end
        last_fd = k;
      end
      bus.load        = ($urandom_range(7) == 0);
      bus.valuein     = 16'($urandom) & masks[$urandom_range(3)];
      bus.decpointsin = ($urandom_range(1) == 0) ? 4'b0000 : 4'($urandom);
      if ($urandom_range(15) == 0) bus.blankzeros = ~bus.blankzeros;
    end
    bus.load = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_load_commit();
    test_blankzeros();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
